// File: rtl/bf_cfg_pkg.sv
// Shared definitions for the butterfly config RAM writer: bank codes, FSM
// encoding and the beat-count derivation with its parameter sanity check.
package bf_cfg_pkg;

    localparam logic [1:0] BANK_A = 2'd0;
    localparam logic [1:0] BANK_B = 2'd1;
    localparam logic [1:0] BANK_C = 2'd2;
    localparam logic [1:0] BANK_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Stream beats needed to build one stage word.
    function automatic int calc_beats(input int cfg_width, input int in_width);
        return cfg_width / in_width;
    endfunction

    // sram_sel is 8 bits wide, so at most 256 stages are addressable.
    function automatic bit cfg_params_ok(input int cfg_width, input int in_width,
                                         input int stage_num);
        return (in_width > 0) && (cfg_width >= in_width) &&
               (cfg_width % in_width == 0) &&
               (stage_num >= 1) && (stage_num <= 256);
    endfunction

endpackage

// File: rtl/bf_cfg_writer_if.sv
// Narrow config stream feeding the writer: valid/ready handshake plus a
// last-beat marker framing one command.
interface bf_cfg_writer_if #(
    parameter int IN_WIDTH = 4
);
    logic                s_valid;
    logic                s_ready;
    logic [IN_WIDTH-1:0] s_data;
    logic                s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/bf_cfg_beat_assembler.sv
// Packs IN_WIDTH stream beats into one CFG_WIDTH stage word, first beat in the
// LSBs, and flags the completing beat and any premature s_last.
module bf_cfg_beat_assembler
    import bf_cfg_pkg::*;
#(
    parameter int CFG_WIDTH = 8,
    parameter int IN_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 ready,
    input  logic                 valid,
    input  logic [IN_WIDTH-1:0]  data,
    input  logic                 last,
    input  logic                 final_stage,
    output logic [CFG_WIDTH-1:0] word,
    output logic                 word_done,
    output logic                 early_last
);
    localparam int BEATS = calc_beats(CFG_WIDTH, IN_WIDTH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BW-1:0]        beat_cnt;
    logic [CFG_WIDTH-1:0] asm_q;
    logic                 fire;
    logic                 final_beat;

    assign fire       = valid & ready;
    assign final_beat = (beat_cnt == BW'(BEATS - 1));
    assign word_done  = fire & final_beat;
    // Only the last beat of the last stage may carry s_last.
    assign early_last = fire & last & ~(final_beat & final_stage);

    // word already includes the beat on the bus so the writer can register it
    // on the same edge the final beat transfers.
    always_comb begin
        word = asm_q;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt == BW'(k)) word[k*IN_WIDTH +: IN_WIDTH] = data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            beat_cnt <= '0;
            asm_q    <= '0;
        end else if (fire) begin
            asm_q    <= word;
            beat_cnt <= final_beat ? '0 : beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bf_cfg_writer.sv
// Loads one entry of a butterfly config bank: collects a stage word from the
// stream, writes it, and repeats for every stage in ascending order.
module bf_cfg_writer
    import bf_cfg_pkg::*;
#(
    parameter int CFG_WIDTH  = 8,
    parameter int STAGE_NUM  = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int IN_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            bank_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    bf_cfg_writer_if.slave        s,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            sram_sel,
    output logic                  wr_en_A,
    output logic                  wr_en_B,
    output logic                  wr_en_C,
    output logic                  wr_en_D,
    output logic [CFG_WIDTH-1:0]  wr_cfg
);
    if (!cfg_params_ok(CFG_WIDTH, IN_WIDTH, STAGE_NUM)) begin : g_bad_params
        $error("bf_cfg_writer: CFG_WIDTH must be a multiple of IN_WIDTH and STAGE_NUM <= 256");
    end

    state_t                state;
    logic [1:0]            bank_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            stage_q;
    logic                  err_pend;
    logic                  final_stage;
    logic [CFG_WIDTH-1:0]  word;
    logic                  word_done;
    logic                  early_last;

    assign final_stage = (stage_q == 8'(STAGE_NUM - 1));

    bf_cfg_beat_assembler #(
        .CFG_WIDTH (CFG_WIDTH),
        .IN_WIDTH  (IN_WIDTH)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clr         (state == ST_IDLE),
        .ready       (s.s_ready),
        .valid       (s.s_valid),
        .data        (s.s_data),
        .last        (s.s_last),
        .final_stage (final_stage),
        .word        (word),
        .word_done   (word_done),
        .early_last  (early_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bank_q    <= '0;
            addr_q    <= '0;
            stage_q   <= '0;
            err_pend  <= 1'b0;
            s.s_ready <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            wr_addr   <= '0;
            sram_sel  <= '0;
            wr_en_A   <= 1'b0;
            wr_en_B   <= 1'b0;
            wr_en_C   <= 1'b0;
            wr_en_D   <= 1'b0;
            wr_cfg    <= '0;
        end else begin
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            wr_en_A <= 1'b0;
            wr_en_B <= 1'b0;
            wr_en_C <= 1'b0;
            wr_en_D <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        bank_q    <= bank_i;
                        addr_q    <= addr_i;
                        stage_q   <= '0;
                        err_pend  <= 1'b0;
                        s.s_ready <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (early_last) begin
                        // Abort: the partial stage is dropped, earlier stages stay.
                        s.s_ready <= 1'b0;
                        busy_o    <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (word_done) begin
                        s.s_ready <= 1'b0;
                        wr_addr   <= addr_q;
                        sram_sel  <= stage_q;
                        wr_cfg    <= word;
                        unique case (bank_q)
                            BANK_A:  wr_en_A <= 1'b1;
                            BANK_B:  wr_en_B <= 1'b1;
                            BANK_C:  wr_en_C <= 1'b1;
                            BANK_D:  wr_en_D <= 1'b1;
                            default: ;
                        endcase
                        // Missing s_last still writes; it is reported with done_o.
                        err_pend  <= final_stage & ~s.s_last;
                        state     <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (final_stage) begin
                        done_o <= 1'b1;
                        err_o  <= err_pend;
                        state  <= ST_DONE;
                    end else begin
                        stage_q   <= stage_q + 8'd1;
                        s.s_ready <= 1'b1;
                        state     <= ST_COLLECT;
                    end
                end

                ST_DONE: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_cfg_writer.sv
// Directed bench for bf_cfg_writer: expected RAM writes go into a scoreboard
// queue as beats are driven and are checked as the write strobes appear.
module tb_bf_cfg_writer;
    import bf_cfg_pkg::*;

    localparam int CFG_WIDTH  = 8;
    localparam int STAGE_NUM  = 2;
    localparam int ADDR_WIDTH = 2;
    localparam int IN_WIDTH   = 4;
    localparam int BEATS      = CFG_WIDTH / IN_WIDTH;
    localparam int LAT        = STAGE_NUM * (BEATS + 1) + 1;

    typedef struct {
        logic [1:0]            bank;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            sel;
        logic [CFG_WIDTH-1:0]  cfg;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start_i;
    logic [1:0]            bank_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  busy_o, done_o, err_o;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            sram_sel;
    logic                  wr_en_A, wr_en_B, wr_en_C, wr_en_D;
    logic [CFG_WIDTH-1:0]  wr_cfg;

    bf_cfg_writer_if #(.IN_WIDTH(IN_WIDTH)) sif ();

    bf_cfg_writer #(
        .CFG_WIDTH(CFG_WIDTH), .STAGE_NUM(STAGE_NUM),
        .ADDR_WIDTH(ADDR_WIDTH), .IN_WIDTH(IN_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .bank_i(bank_i), .addr_i(addr_i),
        .s(sif), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wr_addr(wr_addr), .sram_sel(sram_sel),
        .wr_en_A(wr_en_A), .wr_en_B(wr_en_B), .wr_en_C(wr_en_C), .wr_en_D(wr_en_D),
        .wr_cfg(wr_cfg)
    );

    always #5 clk = ~clk;

    int  tests = 0, fails = 0;
    int  cyc = 0;
    int  done_cnt, err_cnt, done_cyc, err_cyc, wr_cnt;
    int  start_cyc;
    wr_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write/done/err monitor, sampled on the falling edge.
    always @(negedge clk) begin
        int  n;
        wr_t e;
        logic [1:0] b;
        n = int'(wr_en_A) + int'(wr_en_B) + int'(wr_en_C) + int'(wr_en_D);
        if (n != 0) begin
            wr_cnt++;
            chk("wr_en_onehot", 64'(n), 64'd1);
            b = wr_en_B ? BANK_B : wr_en_C ? BANK_C : wr_en_D ? BANK_D : BANK_A;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_bank", 64'(b), 64'(e.bank));
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("sram_sel", 64'(sram_sel), 64'(e.sel));
                chk("wr_cfg", 64'(wr_cfg), 64'(e.cfg));
            end
        end
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (err_o)  begin err_cnt++;  err_cyc  = cyc; end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        done_cnt = 0; err_cnt = 0; wr_cnt = 0; done_cyc = -1; err_cyc = -1;
    endtask

    task automatic do_start(input logic [1:0] b, input logic [ADDR_WIDTH-1:0] a);
        start_i = 1'b1; bank_i = b; addr_i = a;
        start_cyc = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic push(input logic [1:0] b, input logic [ADDR_WIDTH-1:0] a,
                        input logic [7:0] sel, input logic [CFG_WIDTH-1:0] cfg);
        wr_t e;
        e.bank = b; e.addr = a; e.sel = sel; e.cfg = cfg;
        exp_q.push_back(e);
    endtask

    // gap counts cycles where the DUT was ready but no beat was offered.
    task automatic send_beat(input logic [IN_WIDTH-1:0] d, input logic l, input int gap);
        int g = 0;
        int budget = 0;
        bit ok = 1'b0;
        sif.s_valid = 1'b0;
        while (g < gap && budget < 100) begin
            if (sif.s_ready) g++;
            budget++;
            tick();
        end
        sif.s_valid = 1'b1; sif.s_data = d; sif.s_last = l;
        for (int i = 0; i < 50; i++) begin
            if (sif.s_ready) begin ok = 1'b1; tick(); break; end
            tick();
        end
        if (!ok) chk("beat_accept_timeout", 64'(ok), 64'd1);
        sif.s_valid = 1'b0; sif.s_last = 1'b0;
    endtask

    task automatic wait_end();
        int i = 0;
        while (done_cnt + err_cnt == 0 && i < 100) begin tick(); i++; end
        if (done_cnt + err_cnt == 0) chk("end_timeout", 64'(done_cnt + err_cnt), 64'd1);
        tick(); tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_ready"}, 64'(sif.s_ready), 64'd0);
        chk({tag, "_done_err"}, 64'({done_o, err_o}), 64'd0);
        chk({tag, "_wren"}, 64'({wr_en_A, wr_en_B, wr_en_C, wr_en_D}), 64'd0);
        chk({tag, "_wrbus"}, 64'({wr_addr, sram_sel, wr_cfg}), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; bank_i = '0; addr_i = '0;
        sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0;
        clear_stats();
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();
        check_outputs_zero("idle");

        // Beats offered while idle must not be consumed.
        sif.s_valid = 1'b1; sif.s_data = 4'hF;
        tick(); tick();
        chk("idle_ready", 64'(sif.s_ready), 64'd0);
        sif.s_valid = 1'b0;

        // Nominal write, stream held high.
        clear_stats();
        push(BANK_C, 2'd1, 8'd0, 8'hA5);
        push(BANK_C, 2'd1, 8'd1, 8'hC3);
        do_start(BANK_C, 2'd1);
        chk("busy_after_start", 64'(busy_o), 64'd1);
        send_beat(4'h5, 1'b0, 0);
        send_beat(4'hA, 1'b0, 0);
        send_beat(4'h3, 1'b0, 0);
        send_beat(4'hC, 1'b1, 0);
        wait_end();
        chk("nom_latency", 64'(done_cyc - (start_cyc + 1) + 1), 64'(LAT));
        chk("nom_done_err", 64'({done_cnt[3:0], err_cnt[3:0]}), 64'h10);
        chk("nom_writes", 64'(wr_cnt), 64'd2);
        chk("nom_hold_bus", 64'({wr_addr, sram_sel, wr_cfg}), 64'({2'd1, 8'd1, 8'hC3}));
        chk("nom_idle_busy", 64'(busy_o), 64'd0);

        // Same stream with three stalled cycles before each later beat.
        clear_stats();
        push(BANK_C, 2'd1, 8'd0, 8'hA5);
        push(BANK_C, 2'd1, 8'd1, 8'hC3);
        do_start(BANK_C, 2'd1);
        send_beat(4'h5, 1'b0, 0);
        send_beat(4'hA, 1'b0, 3);
        send_beat(4'h3, 1'b0, 3);
        send_beat(4'hC, 1'b1, 3);
        wait_end();
        chk("gap_latency", 64'(done_cyc - (start_cyc + 1) + 1), 64'(LAT + 9));
        chk("gap_done_err", 64'({done_cnt[3:0], err_cnt[3:0]}), 64'h10);
        chk("gap_writes", 64'(wr_cnt), 64'd2);

        // Early s_last in stage 1: stage 0 written, then abort.
        clear_stats();
        push(BANK_A, 2'd3, 8'd0, 8'h21);
        do_start(BANK_A, 2'd3);
        send_beat(4'h1, 1'b0, 0);
        send_beat(4'h2, 1'b0, 0);
        send_beat(4'h7, 1'b1, 0);
        wait_end();
        chk("early_done_err", 64'({done_cnt[3:0], err_cnt[3:0]}), 64'h01);
        chk("early_writes", 64'(wr_cnt), 64'd1);
        chk("early_busy", 64'(busy_o), 64'd0);
        chk("early_ready", 64'(sif.s_ready), 64'd0);

        // Missing s_last: both writes land, err_o rides with done_o.
        clear_stats();
        push(BANK_D, 2'd2, 8'd0, 8'h69);
        push(BANK_D, 2'd2, 8'd1, 8'h0F);
        do_start(BANK_D, 2'd2);
        send_beat(4'h9, 1'b0, 0);
        send_beat(4'h6, 1'b0, 0);
        send_beat(4'hF, 1'b0, 0);
        send_beat(4'h0, 1'b0, 0);
        wait_end();
        chk("nolast_done_err", 64'({done_cnt[3:0], err_cnt[3:0]}), 64'h11);
        chk("nolast_same_cycle", 64'(err_cyc), 64'(done_cyc));
        chk("nolast_writes", 64'(wr_cnt), 64'd2);

        // Reset after the third beat; stage 1 must never be written.
        clear_stats();
        push(BANK_B, 2'd0, 8'd0, 8'h84);
        do_start(BANK_B, 2'd0);
        send_beat(4'h4, 1'b0, 0);
        send_beat(4'h8, 1'b0, 0);
        send_beat(4'hE, 1'b0, 0);
        rst = 1'b1;
        tick();
        check_outputs_zero("midrst");
        rst = 1'b0;
        repeat (4) tick();
        chk("midrst_writes", 64'(wr_cnt), 64'd1);
        chk("midrst_done_err", 64'({done_cnt[3:0], err_cnt[3:0]}), 64'h00);
        clear_stats();
        push(BANK_C, 2'd3, 8'd0, 8'h21);
        push(BANK_C, 2'd3, 8'd1, 8'h43);
        do_start(BANK_C, 2'd3);
        send_beat(4'h1, 1'b0, 0);
        send_beat(4'h2, 1'b0, 0);
        send_beat(4'h3, 1'b0, 0);
        send_beat(4'h4, 1'b1, 0);
        wait_end();
        chk("postrst_latency", 64'(done_cyc - (start_cyc + 1) + 1), 64'(LAT));
        chk("postrst_done_err", 64'({done_cnt[3:0], err_cnt[3:0]}), 64'h10);

        // A second start during COLLECT is ignored.
        clear_stats();
        push(BANK_B, 2'd2, 8'd0, 8'h76);
        push(BANK_B, 2'd2, 8'd1, 8'h98);
        do_start(BANK_B, 2'd2);
        send_beat(4'h6, 1'b0, 0);
        start_i = 1'b1; bank_i = BANK_D; addr_i = 2'd0;
        tick();
        start_i = 1'b0;
        send_beat(4'h7, 1'b0, 0);
        send_beat(4'h8, 1'b0, 0);
        send_beat(4'h9, 1'b1, 0);
        wait_end();
        chk("busy_start_latency", 64'(done_cyc - (start_cyc + 1) + 1), 64'(LAT + 1));
        chk("busy_start_done_err", 64'({done_cnt[3:0], err_cnt[3:0]}), 64'h10);
        chk("busy_start_writes", 64'(wr_cnt), 64'd2);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
